// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage
//   Owns the fetch PC, issues at most one outstanding I-cache request and queues fetched
//   instructions (or fetch-side exceptions) in a FETCH_DEPTH-entry FIFO toward decode.
//   Redirects flush the queue and toggle an epoch bit so that in-flight responses are dropped.
// Ports
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   stall_i                    blocks new I-cache requests only
//   redirect_valid_i/pc_i      redirect (highest priority)
//   icache_req_*               request channel (valid/ready, vaddr, epoch tag)
//   icache_resp_*              response channel (valid, epoch echo, data, access/page fault)
//   fetch_*                    head-of-queue toward decode (valid/ready, pc, inst, exception)
module fetch_queue_stage #(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     VADDR_W     = 40,
  parameter int unsigned     INST_W      = 32,
  parameter int unsigned     FETCH_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = 'h200
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               stall_i,
  input  logic               redirect_valid_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               icache_req_valid_o,
  input  logic               icache_req_ready_i,
  output logic [VADDR_W-1:0] icache_req_vaddr_o,
  output logic               icache_req_epoch_o,
  input  logic               icache_resp_valid_i,
  input  logic               icache_resp_epoch_i,
  input  logic [INST_W-1:0]  icache_resp_data_i,
  input  logic               icache_resp_afault_i,
  input  logic               icache_resp_pfault_i,
  output logic               fetch_valid_o,
  input  logic               fetch_ready_i,
  output logic [XLEN-1:0]    fetch_pc_o,
  output logic [INST_W-1:0]  fetch_inst_o,
  output logic               fetch_ex_valid_o,
  output logic [3:0]         fetch_ex_cause_o
);

  localparam int unsigned PtrW = $clog2(FETCH_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StFetch, StWait, StHalt} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              epoch_q, epoch_d;
  // Holds off the first request until the cycle after reset release.
  logic              run_q;

  logic [XLEN-1:0]   q_pc    [FETCH_DEPTH];
  logic [INST_W-1:0] q_inst  [FETCH_DEPTH];
  logic              q_ex    [FETCH_DEPTH];
  logic [3:0]        q_cause [FETCH_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;

  logic              has_room, can_fetch, misaligned, out_of_range, pop;
  logic              push;
  logic [XLEN-1:0]   push_pc;
  logic [INST_W-1:0] push_inst;
  logic              push_ex;
  logic [3:0]        push_cause;

  // The outstanding request already owns a slot, so room is only checked at issue time.
  assign has_room     = count_q < CntW'(FETCH_DEPTH);
  assign can_fetch    = run_q && (state_q == StFetch) && !stall_i && has_room;
  assign misaligned   = |pc_q[1:0];
  assign out_of_range = |pc_q[XLEN-1:VADDR_W];

  assign icache_req_valid_o = can_fetch && !misaligned && !out_of_range && !redirect_valid_i;
  assign icache_req_vaddr_o = pc_q[VADDR_W-1:0];
  assign icache_req_epoch_o = epoch_q;

  assign fetch_valid_o    = (count_q != '0);
  assign pop              = fetch_valid_o && fetch_ready_i;
  assign fetch_pc_o       = fetch_valid_o ? q_pc[rptr_q]    : '0;
  assign fetch_inst_o     = fetch_valid_o ? q_inst[rptr_q]  : '0;
  assign fetch_ex_valid_o = fetch_valid_o ? q_ex[rptr_q]    : 1'b0;
  assign fetch_ex_cause_o = fetch_valid_o ? q_cause[rptr_q] : 4'd0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    epoch_d    = epoch_q;
    push       = 1'b0;
    push_pc    = pc_q;
    push_inst  = '0;
    push_ex    = 1'b0;
    push_cause = 4'd0;

    unique case (state_q)
      StFetch: begin
        if (can_fetch) begin
          if (misaligned) begin
            push       = 1'b1;
            push_ex    = 1'b1;
            push_cause = 4'd0;
            state_d    = StHalt;
          end else if (out_of_range) begin
            push       = 1'b1;
            push_ex    = 1'b1;
            push_cause = 4'd1;
            state_d    = StHalt;
          end else if (icache_req_ready_i) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
            state_d  = StWait;
          end
        end
      end
      StWait: begin
        if (icache_resp_valid_i) begin
          state_d = StFetch;
          if (icache_resp_epoch_i == epoch_q) begin
            push    = 1'b1;
            push_pc = req_pc_q;
            push_ex = icache_resp_afault_i || icache_resp_pfault_i;
            if (icache_resp_afault_i) begin
              push_cause = 4'd1;
            end else if (icache_resp_pfault_i) begin
              push_cause = 4'd12;
            end
            push_inst = push_ex ? '0 : icache_resp_data_i;
            if (push_ex) begin
              state_d = StHalt;
            end
          end
        end
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase

    // Redirect overrides everything; an outstanding response will come back stale.
    if (redirect_valid_i) begin
      push     = 1'b0;
      pc_d     = redirect_pc_i;
      req_pc_d = req_pc_q;
      epoch_d  = ~epoch_q;
      state_d  = (state_q == StWait && !icache_resp_valid_i) ? StWait : StFetch;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      epoch_q  <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      epoch_q  <= epoch_d;
      run_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (redirect_valid_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Payload storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pc[wptr_q]    <= push_pc;
      q_inst[wptr_q]  <= push_inst;
      q_ex[wptr_q]    <= push_ex;
      q_cause[wptr_q] <= push_cause;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage
//   Drives fetch_queue_stage with directed and randomized traffic from a small I-cache
//   responder and compares every cycle against a transaction-level reference model.
module tb_fetch_queue_stage;

  localparam int DEPTH = 4;

  logic        clk, rstn, stall, redir;
  logic [63:0] rpc;
  logic        req_valid, req_ready, req_epoch;
  logic [39:0] vaddr;
  logic        resp_valid, resp_epoch, resp_af, resp_pf;
  logic [31:0] resp_data;
  logic        fvalid, fready, fex;
  logic [63:0] fpc;
  logic [31:0] finst;
  logic [3:0]  fcause;

  fetch_queue_stage dut (
    .clk_i               (clk),
    .rstn_i              (rstn),
    .stall_i             (stall),
    .redirect_valid_i    (redir),
    .redirect_pc_i       (rpc),
    .icache_req_valid_o  (req_valid),
    .icache_req_ready_i  (req_ready),
    .icache_req_vaddr_o  (vaddr),
    .icache_req_epoch_o  (req_epoch),
    .icache_resp_valid_i (resp_valid),
    .icache_resp_epoch_i (resp_epoch),
    .icache_resp_data_i  (resp_data),
    .icache_resp_afault_i(resp_af),
    .icache_resp_pfault_i(resp_pf),
    .fetch_valid_o       (fvalid),
    .fetch_ready_i       (fready),
    .fetch_pc_o          (fpc),
    .fetch_inst_o        (finst),
    .fetch_ex_valid_o    (fex),
    .fetch_ex_cause_o    (fcause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [3:0]  cause;
  } ent_t;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: next fetch address, epoch, halted / outstanding flags, queue contents.
  ent_t        mq[$];
  logic [63:0] m_pc, m_req_pc;
  logic        m_epoch, m_halt, m_out, m_run;

  // I-cache responder state.
  logic        pend, pend_epoch;
  int unsigned pend_dly;

  // Knobs (percent) and one-shot directed controls.
  int unsigned k_stall, k_ready, k_fready, k_redir, k_fault, k_dly_min, k_dly_max;
  logic        force_redir, force_pf;
  logic [63:0] force_pc;

  // Observed traffic.
  int          hs_cnt;
  logic [63:0] hs_addr[$];
  logic [63:0] last_vaddr;
  logic [63:0] lp_pc;
  logic [31:0] lp_inst;
  logic        lp_ex;
  logic [3:0]  lp_cause;
  int          hs0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] rand_target();
    int unsigned s;
    s = $urandom_range(0, 9);
    case (s)
      0:       return {46'd0, 16'($urandom_range(0, 65535)), 2'b10};
      1:       return 64'h0000_0100_0000_0000 | {48'd0, 14'($urandom_range(0, 16383)), 2'b00};
      2:       return 64'hFFFF_FFFF_FFFF_FFF0;
      default: return {46'd0, 16'($urandom_range(0, 65535)), 2'b00};
    endcase
  endfunction

  task automatic do_reset();
    rstn       = 1'b0;
    stall      = 1'b0;
    redir      = 1'b0;
    rpc        = '0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_epoch = 1'b0;
    resp_data  = '0;
    resp_af    = 1'b0;
    resp_pf    = 1'b0;
    fready     = 1'b0;
    #1;
    check_eq("rst_req_valid", req_valid, 0);
    check_eq("rst_vaddr", vaddr, 64'h200);
    check_eq("rst_epoch", req_epoch, 0);
    check_eq("rst_fvalid", fvalid, 0);
    check_eq("rst_fpc", fpc, 0);
    check_eq("rst_finst", finst, 0);
    check_eq("rst_fex", fex, 0);
    check_eq("rst_fcause", fcause, 0);
    mq.delete();
    m_pc = 64'h200; m_req_pc = '0; m_epoch = 1'b0; m_halt = 1'b0; m_out = 1'b0; m_run = 1'b0;
    pend = 1'b0; pend_epoch = 1'b0; pend_dly = 0;
    force_redir = 1'b0; force_pf = 1'b0;
    hs_cnt = 0; hs_addr.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // One cycle: called at a negedge, returns at the next negedge.
  task automatic step();
    logic        d_stall, d_rdy, d_frdy, d_redir, d_rv, d_rep, d_af, d_pf, allowed;
    logic        room, go, misal, hi, exp_req;
    logic [63:0] d_rpc;
    logic [31:0] d_data;
    ent_t        e;

    d_stall = ($urandom_range(0, 99) < k_stall);
    d_rdy   = ($urandom_range(0, 99) < k_ready);
    d_frdy  = ($urandom_range(0, 99) < k_fready);
    // Never redirect twice while a stale response is still in flight (epoch would alias).
    allowed = !(pend && (pend_epoch != m_epoch));
    d_redir = 1'b0;
    d_rpc   = '0;
    if (force_redir && allowed) begin
      d_redir     = 1'b1;
      d_rpc       = force_pc;
      force_redir = 1'b0;
    end else if (!force_redir && allowed && ($urandom_range(0, 99) < k_redir)) begin
      d_redir = 1'b1;
      d_rpc   = rand_target();
    end
    d_rv = 1'b0; d_rep = 1'b0; d_data = '0; d_af = 1'b0; d_pf = 1'b0;
    if (pend) begin
      if (pend_dly == 0) begin
        d_rv   = 1'b1;
        d_rep  = pend_epoch;
        d_data = $urandom;
        if (force_pf) begin
          d_pf     = 1'b1;
          force_pf = 1'b0;
        end else begin
          d_af = ($urandom_range(0, 99) < k_fault);
          d_pf = ($urandom_range(0, 99) < k_fault);
        end
        pend = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    stall = d_stall; req_ready = d_rdy; fready = d_frdy; redir = d_redir; rpc = d_rpc;
    resp_valid = d_rv; resp_epoch = d_rep; resp_data = d_data; resp_af = d_af; resp_pf = d_pf;
    #1;

    room    = (mq.size() < DEPTH);
    go      = m_run && !m_halt && !m_out && !d_stall && room;
    misal   = (m_pc[1:0] != 2'b00);
    hi      = (m_pc[63:40] != 24'd0);
    exp_req = go && !misal && !hi && !d_redir;

    check_eq("req_valid", req_valid, exp_req);
    if (exp_req) begin
      check_eq("req_vaddr", vaddr, m_pc[39:0]);
      check_eq("req_epoch", req_epoch, m_epoch);
    end
    check_eq("fetch_valid", fvalid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_eq("fetch_pc", fpc, mq[0].pc);
      check_eq("fetch_inst", finst, mq[0].inst);
      check_eq("fetch_ex", fex, mq[0].ex);
      check_eq("fetch_cause", fcause, mq[0].cause);
    end

    if (fvalid && d_frdy) begin
      lp_pc = fpc; lp_inst = finst; lp_ex = fex; lp_cause = fcause;
    end
    if (req_valid && d_rdy) begin
      pend       = 1'b1;
      pend_epoch = req_epoch;
      pend_dly   = $urandom_range(k_dly_min, k_dly_max);
      hs_cnt++;
      last_vaddr = {24'd0, vaddr};
      hs_addr.push_back(last_vaddr);
    end

    if (d_redir) begin
      mq.delete();
      if (m_out && d_rv) m_out = 1'b0;
      m_pc    = d_rpc;
      m_epoch = ~m_epoch;
      m_halt  = 1'b0;
    end else begin
      if (mq.size() != 0 && d_frdy) void'(mq.pop_front());
      if (m_out && d_rv) begin
        m_out = 1'b0;
        if (d_rep == m_epoch) begin
          e.pc    = m_req_pc;
          e.ex    = d_af | d_pf;
          e.inst  = e.ex ? 32'd0 : d_data;
          e.cause = d_af ? 4'd1 : (d_pf ? 4'd12 : 4'd0);
          mq.push_back(e);
          if (e.ex) m_halt = 1'b1;
        end
      end else if (go && misal) begin
        e = '{pc: m_pc, inst: 32'd0, ex: 1'b1, cause: 4'd0};
        mq.push_back(e);
        m_halt = 1'b1;
      end else if (go && hi) begin
        e = '{pc: m_pc, inst: 32'd0, ex: 1'b1, cause: 4'd1};
        mq.push_back(e);
        m_halt = 1'b1;
      end else if (exp_req && d_rdy) begin
        m_req_pc = m_pc;
        m_out    = 1'b1;
        m_pc     = m_pc + 64'd4;
      end
    end
    m_run = 1'b1;
    @(negedge clk);
  endtask

  task automatic directed_knobs();
    k_stall = 0; k_ready = 100; k_fready = 100; k_redir = 0; k_fault = 0;
    k_dly_min = 0; k_dly_max = 0;
  endtask

  initial begin
    rstn = 1'b0;
    lp_pc = '0; lp_inst = '0; lp_ex = 1'b0; lp_cause = '0; last_vaddr = '0;
    directed_knobs();
    @(negedge clk);

    // Sequential fetch from reset, one-cycle responses.
    do_reset();
    for (int i = 0; i < 20 && hs_cnt < 3; i++) step();
    check_eq("seq_hs_cnt", hs_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("seq_vaddr", (i < hs_addr.size()) ? hs_addr[i] : 64'hdead, 64'h200 + 64'(4 * i));
    end
    repeat (8) step();

    // Decode blocked: only DEPTH requests may be accepted.
    do_reset();
    k_fready = 0;
    repeat (30) step();
    check_eq("full_hs_cnt", hs_cnt, DEPTH);
    k_fready = 100;
    repeat (10) step();
    check_eq("full_resume", hs_cnt > DEPTH, 1);

    // Redirect while waiting on 0x208.
    do_reset();
    k_dly_min = 3; k_dly_max = 3;
    for (int i = 0; i < 40 && hs_cnt < 3; i++) step();
    check_eq("redir_wait_vaddr", last_vaddr, 64'h208);
    force_pc = 64'h1000; force_redir = 1'b1;
    step();
    check_eq("redir_flushed", fvalid, 0);
    for (int i = 0; i < 40 && hs_cnt < 4; i++) step();
    check_eq("redir_new_vaddr", last_vaddr, 64'h1000);
    k_dly_min = 0; k_dly_max = 0;

    // Misaligned redirect target.
    hs0 = hs_cnt;
    force_pc = 64'h202; force_redir = 1'b1;
    repeat (15) step();
    check_eq("misal_no_req", hs_cnt, hs0);
    check_eq("misal_pc", lp_pc, 64'h202);
    check_eq("misal_ex", lp_ex, 1);
    check_eq("misal_cause", lp_cause, 0);
    check_eq("misal_inst", lp_inst, 0);

    // Unimplemented high address bits.
    force_pc = 64'h100_0000_0000; force_redir = 1'b1;
    repeat (12) step();
    check_eq("range_no_req", hs_cnt, hs0);
    check_eq("range_pc", lp_pc, 64'h100_0000_0000);
    check_eq("range_ex", lp_ex, 1);
    check_eq("range_cause", lp_cause, 1);

    // Page fault response halts fetch until the next redirect.
    force_pc = 64'h300; force_redir = 1'b1; force_pf = 1'b1;
    repeat (12) step();
    check_eq("pf_one_req", hs_cnt, hs0 + 1);
    check_eq("pf_pc", lp_pc, 64'h300);
    check_eq("pf_ex", lp_ex, 1);
    check_eq("pf_cause", lp_cause, 12);
    check_eq("pf_inst", lp_inst, 0);
    force_pc = 64'h400; force_redir = 1'b1;
    repeat (12) step();
    check_eq("pf_resume", hs_cnt > hs0 + 1, 1);

    // Randomized traffic with a reset in the middle.
    k_stall = 20; k_ready = 60; k_fready = 60; k_redir = 4; k_fault = 5;
    k_dly_min = 0; k_dly_max = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
